// File: rtl/egress_read_scheduler.sv
// Egress read scheduler: per output port, round-robin selection of a non-empty source VOQ,
// credit-guarded read issue, and a first-word-fall-through output FIFO towards the MAC.
module egress_read_scheduler #(
   parameter int unsigned N          = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned OBUF_DEPTH = 4,
   localparam int unsigned WS        = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N*N-1:0]          empty_i,
   input  logic [N*DATA_WIDTH-1:0] voq_data_i,
   output logic [N*WS-1:0]         rd_sel_o,
   output logic [N-1:0]            rd_en_o,
   output logic [N-1:0]            tx_valid_o,
   input  logic [N-1:0]            tx_ready_i,
   output logic [N*DATA_WIDTH-1:0] tx_data_o,
   output logic [N*WS-1:0]         tx_src_o
);
   localparam int unsigned CW = $clog2(OBUF_DEPTH + 1);
   localparam int unsigned PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [N-1:0]          elig;
      logic                  issue;
      logic [WS-1:0]         pick;
      logic                  push;
      logic                  pop;
      logic                  rd_en_q;
      logic [WS-1:0]         rd_sel_q;
      logic [WS-1:0]         rr_ptr_q;
      logic [CW-1:0]         credit_q;
      logic [RD_LATENCY-1:0] pv_q;
      logic [WS-1:0]         ps_q [RD_LATENCY];
      logic [DATA_WIDTH-1:0] fd_q [OBUF_DEPTH];
      logic [WS-1:0]         fs_q [OBUF_DEPTH];
      logic [PW-1:0]         wp_q;
      logic [PW-1:0]         rp_q;
      logic [CW-1:0]         cnt_q;

      // Mask the source strobed this cycle: its empty flag lags the read by one cycle.
      always_comb begin
         elig = ~empty_i[i*N +: N];
         if (rd_en_q) elig[rd_sel_q] = 1'b0;
      end

      // Round-robin pick of the first eligible source at or after rr_ptr_q, gated by credit.
      always_comb begin
         int unsigned idx;
         idx   = 0;
         issue = 1'b0;
         pick  = rr_ptr_q;
         for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr_q) + k) % N;
            if (!issue && elig[idx]) begin
               issue = 1'b1;
               pick  = WS'(idx);
            end
         end
         if (credit_q == '0) issue = 1'b0;
      end

      assign push = pv_q[RD_LATENCY-1];
      assign pop  = (cnt_q != '0) && tx_ready_i[i];

      // Registered read strobe/select, round-robin pointer and credit counter.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_en_q  <= 1'b0;
            rd_sel_q <= '0;
            rr_ptr_q <= '0;
            credit_q <= CW'(OBUF_DEPTH);
         end else begin
            rd_en_q <= issue;
            if (issue) begin
               rd_sel_q <= pick;
               rr_ptr_q <= (pick == WS'(N - 1)) ? '0 : pick + 1'b1;
            end
            // A credit is taken at the decision so the registered strobe is already counted.
            credit_q <= credit_q - CW'(issue) + CW'(pop);
         end
      end

      // Return pipeline: carries {valid, src} alongside the VOQ read latency.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pv_q <= '0;
            for (int j = 0; j < RD_LATENCY; j++) ps_q[j] <= '0;
         end else begin
            pv_q[0] <= rd_en_q;
            ps_q[0] <= rd_sel_q;
            for (int j = 1; j < RD_LATENCY; j++) begin
               pv_q[j] <= pv_q[j-1];
               ps_q[j] <= ps_q[j-1];
            end
         end
      end

      // Output FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
         end
      end

      // FIFO storage; stale entries are never visible because outputs are gated by occupancy.
      always_ff @(posedge clk) begin
         if (push) begin
            fd_q[wp_q] <= voq_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            fs_q[wp_q] <= ps_q[RD_LATENCY-1];
         end
      end

      assign rd_en_o[i]                         = rd_en_q;
      assign rd_sel_o[i*WS +: WS]               = rd_sel_q;
      assign tx_valid_o[i]                      = (cnt_q != '0);
      assign tx_data_o[i*DATA_WIDTH +: DATA_WIDTH] = (cnt_q != '0) ? fd_q[rp_q] : '0;
      assign tx_src_o[i*WS +: WS]               = (cnt_q != '0) ? fs_q[rp_q] : '0;
   end

endmodule

// File: tb/tb_egress_read_scheduler.sv
// Bench for egress_read_scheduler: instance 0 at RD_LATENCY=1, instance 1 at RD_LATENCY=3,
// each fed by a behavioural VOQ bank. Words encode {lane, src, sequence}.
module tb_egress_read_scheduler;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int WS = 2;
   localparam int OD = 4;

   typedef struct {
      logic [N*N-1:0] empty;
      logic [N-1:0]   ready;
      logic [N-1:0]   exp_en;
      logic [1:0]     exp_sel;
      logic           exp_vld;
      logic [1:0]     exp_src;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N*N-1:0]  empty_w    [2];
   logic [N*DW-1:0] vdata_w    [2];
   logic [N*WS-1:0] rd_sel_w   [2];
   logic [N-1:0]    rd_en_w    [2];
   logic [N-1:0]    tx_valid_w [2];
   logic [N-1:0]    tx_ready_r [2];
   logic [N*DW-1:0] tx_data_w  [2];
   logic [N*WS-1:0] tx_src_w   [2];

   egress_read_scheduler #(.N(N), .DATA_WIDTH(DW), .RD_LATENCY(1), .OBUF_DEPTH(OD)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .empty_i(empty_w[0]), .voq_data_i(vdata_w[0]),
      .rd_sel_o(rd_sel_w[0]), .rd_en_o(rd_en_w[0]), .tx_valid_o(tx_valid_w[0]),
      .tx_ready_i(tx_ready_r[0]), .tx_data_o(tx_data_w[0]), .tx_src_o(tx_src_w[0]));

   egress_read_scheduler #(.N(N), .DATA_WIDTH(DW), .RD_LATENCY(3), .OBUF_DEPTH(OD)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .empty_i(empty_w[1]), .voq_data_i(vdata_w[1]),
      .rd_sel_o(rd_sel_w[1]), .rd_en_o(rd_en_w[1]), .tx_valid_o(tx_valid_w[1]),
      .tx_ready_i(tx_ready_r[1]), .tx_data_o(tx_data_w[1]), .tx_src_o(tx_src_w[1]));

   // Behavioural VOQ bank: FIFO per (instance, lane, source), read data delayed by latency.
   logic [DW-1:0]  mem [2][N][N][64];
   int             tl  [2][N][N];
   int             hd  [2][N][N];
   logic [DW-1:0]  dp  [2][N][3];
   logic           tbl_mode;
   logic [N*N-1:0] tbl_empty;

   always_comb begin
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < N; i++)
            for (int s = 0; s < N; s++)
               empty_w[m][i*N+s] = (hd[m][i][s] == tl[m][i][s]);
      if (tbl_mode) empty_w[0] = tbl_empty;
      for (int i = 0; i < N; i++) begin
         vdata_w[0][i*DW +: DW] = dp[0][i][0];
         vdata_w[1][i*DW +: DW] = dp[1][i][2];
      end
   end

   always_ff @(posedge clk) begin
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < N; i++) begin
            if (rd_en_w[m][i]) begin
               if (hd[m][i][rd_sel_w[m][i*WS +: WS]] < tl[m][i][rd_sel_w[m][i*WS +: WS]]) begin
                  dp[m][i][0] <= mem[m][i][rd_sel_w[m][i*WS +: WS]]
                                    [hd[m][i][rd_sel_w[m][i*WS +: WS]]];
                  hd[m][i][rd_sel_w[m][i*WS +: WS]] <= hd[m][i][rd_sel_w[m][i*WS +: WS]] + 1;
               end else begin
                  dp[m][i][0] <= 16'hDEAD;
               end
            end
            dp[m][i][1] <= dp[m][i][0];
            dp[m][i][2] <= dp[m][i][1];
         end
   end

   int   tests = 0;
   int   fails = 0;
   int   exp_seq   [2][N][N];
   int   delivered [2][N];
   logic mon_en;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input int m, input int i, input int s, input int n);
      for (int k = 0; k < n; k++) begin
         mem[m][i][s][tl[m][i][s]] = {4'(i), 4'(s), 8'(tl[m][i][s])};
         tl[m][i][s]++;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Transfer scoreboard: per source, words must arrive in order with none lost or repeated.
   task automatic monitor();
      logic [DW-1:0] d;
      logic [1:0]    src;
      forever begin
         @(negedge clk);
         #2;
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) begin
               if (!rst_n) begin
                  for (int s = 0; s < N; s++) exp_seq[m][i][s] = hd[m][i][s];
               end else if (mon_en && tx_valid_w[m][i] && tx_ready_r[m][i]) begin
                  d   = tx_data_w[m][i*DW +: DW];
                  src = tx_src_w[m][i*WS +: WS];
                  chk($sformatf("xfer m%0d l%0d", m, i), 64'(d),
                      64'({4'(i), 2'b00, src, 8'(exp_seq[m][i][src])}));
                  exp_seq[m][i][src]++;
                  delivered[m][i]++;
               end
            end
      end
   endtask

   function automatic bit all_drained();
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < N; i++)
            for (int s = 0; s < N; s++)
               if (exp_seq[m][i][s] != tl[m][i][s]) return 1'b0;
      return 1'b1;
   endfunction

   vec_t tbl[17];
   int   base;
   int   nrd;

   initial begin
      tbl[0]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd1, 1'b0, 2'd0};
      tbl[1]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd2, 1'b0, 2'd0};
      tbl[2]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd3, 1'b1, 2'd1};
      tbl[3]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd1, 1'b1, 2'd2};
      tbl[4]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd2, 1'b1, 2'd3};
      tbl[5]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd3, 1'b1, 2'd1};
      tbl[6]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd1, 1'b1, 2'd2};
      tbl[7]  = '{16'hFFF1, 4'hF, 4'b0001, 2'd2, 1'b1, 2'd3};
      tbl[8]  = '{16'hFFFF, 4'hF, 4'b0000, 2'd2, 1'b1, 2'd1};
      tbl[9]  = '{16'hFFFF, 4'hF, 4'b0000, 2'd2, 1'b1, 2'd2};
      tbl[10] = '{16'hFFFF, 4'hF, 4'b0000, 2'd2, 1'b0, 2'd0};
      tbl[11] = '{16'hFFFE, 4'hF, 4'b0001, 2'd0, 1'b0, 2'd0};
      tbl[12] = '{16'hFFFE, 4'hF, 4'b0000, 2'd0, 1'b0, 2'd0};
      tbl[13] = '{16'hFFFE, 4'hF, 4'b0001, 2'd0, 1'b1, 2'd0};
      tbl[14] = '{16'hFFFF, 4'hE, 4'b0000, 2'd0, 1'b1, 2'd0};
      tbl[15] = '{16'hFFFF, 4'hF, 4'b0000, 2'd0, 1'b1, 2'd0};
      tbl[16] = '{16'hFFFF, 4'hF, 4'b0000, 2'd0, 1'b0, 2'd0};

      rst_n         = 1'b0;
      tbl_mode      = 1'b0;
      tbl_empty     = '1;
      mon_en        = 1'b0;
      tx_ready_r[0] = '1;
      tx_ready_r[1] = '1;
      fork
         monitor();
      join_none

      // Reset and idle with every VOQ empty.
      repeat (3) @(negedge clk);
      chk("in_reset", {rd_en_w[0], rd_en_w[1], tx_valid_w[0], tx_valid_w[1]}, 64'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         chk($sformatf("idle%0d", k),
             {rd_en_w[0], rd_en_w[1], tx_valid_w[0], tx_valid_w[1]}, 64'd0);
      end

      // Lane 0 round robin and FIFO timing, directed empty patterns.
      tbl_mode = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tbl_empty     = tbl[k].empty;
         tx_ready_r[0] = tbl[k].ready;
         cyc(1);
         chk($sformatf("tbl[%0d]", k),
             {rd_en_w[0], rd_sel_w[0][1:0], tx_valid_w[0][0], tx_src_w[0][1:0]},
             {tbl[k].exp_en, tbl[k].exp_sel, tbl[k].exp_vld, tbl[k].exp_src});
      end
      tbl_mode      = 1'b0;
      tx_ready_r[0] = '1;
      mon_en        = 1'b1;
      cyc(2);

      // Lane 1, single busy source: one read every other cycle.
      base = delivered[0][1];
      load(0, 1, 2, 5);
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         chk($sformatf("single%0d", k), {rd_en_w[0][1], rd_sel_w[0][3:2]},
             {((k % 2) == 1) && (k <= 9), 2'd2});
      end
      for (int c = 0; c < 30 && delivered[0][1] != base + 5; c++) cyc(1);
      chk("single_count", 64'(delivered[0][1] - base), 64'd5);

      // Lane 2 stalled by the MAC: credit allows exactly OBUF_DEPTH reads.
      base          = delivered[0][2];
      tx_ready_r[0] = 4'b1011;
      load(0, 2, 0, 6);
      load(0, 2, 1, 6);
      load(0, 2, 3, 6);
      nrd = 0;
      for (int k = 0; k < 16; k++) begin
         cyc(1);
         if (rd_en_w[0][2]) nrd++;
      end
      chk("stall_reads", 64'(nrd), 64'(OD));
      chk("stall_valid", 64'(tx_valid_w[0][2]), 64'd1);
      tx_ready_r[0] = '1;
      for (int c = 0; c < 100 && delivered[0][2] != base + 18; c++) cyc(1);
      chk("stall_resume", 64'(delivered[0][2] - base), 64'd18);

      // RD_LATENCY=3 instance, every lane busy, MAC ready toggling.
      for (int i = 0; i < N; i++)
         for (int s = 0; s < N; s++)
            if (s != i) load(1, i, s, 8);
      for (int c = 0; c < 600; c++) begin
         if (delivered[1][0] == 24 && delivered[1][1] == 24 &&
             delivered[1][2] == 24 && delivered[1][3] == 24) break;
         tx_ready_r[1] = ((c % 2) == 0) ? 4'hF : 4'h0;
         cyc(1);
      end
      tx_ready_r[1] = '1;
      for (int i = 0; i < N; i++)
         chk($sformatf("lat3_lane%0d", i), 64'(delivered[1][i]), 64'd24);

      // Asynchronous reset with reads in flight on the RD_LATENCY=3 instance.
      load(1, 0, 1, 4);
      cyc(5);
      chk("pre_rst", {rd_en_w[1][0], tx_valid_w[1][0]}, 64'b11);
      rst_n = 1'b0;
      #1;
      chk("async_rst", {rd_en_w[1], rd_sel_w[1], tx_valid_w[1], tx_data_w[1], tx_src_w[1]},
          64'd0);
      repeat (2) @(negedge clk);
      tx_ready_r[1] = '0;
      load(1, 0, 2, 4);
      load(1, 0, 3, 4);
      rst_n = 1'b1;
      cyc(1);
      chk("no_stale", 64'(tx_valid_w[1]), 64'd0);
      nrd = (rd_en_w[1][0]) ? 1 : 0;
      for (int k = 0; k < 29; k++) begin
         cyc(1);
         if (rd_en_w[1][0]) nrd++;
      end
      chk("rst_credit", 64'(nrd), 64'(OD));
      tx_ready_r[1] = '1;
      for (int c = 0; c < 200 && !all_drained(); c++) cyc(1);
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < N; i++)
            for (int s = 0; s < N; s++)
               if (tl[m][i][s] != 0)
                  chk($sformatf("drain m%0d l%0d s%0d", m, i, s),
                      64'(exp_seq[m][i][s]), 64'(tl[m][i][s]));
      chk("final_idle", {rd_en_w[0], rd_en_w[1], tx_valid_w[0], tx_valid_w[1]}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
